keyword_feeder: RTL and testbench

- Supplies keyword batches to the string matcher over its weight interface.
- Stores a byte-stream keyword list, packs whole keywords into the lane vector, and pulses weight_enable once per batch.
- Waits for the matcher's done, then issues the next batch. On the last batch of the list it raises string_finish so the matcher advances to the next string.

---
 rtl/keyword_feeder.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_keyword_feeder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyword_feeder.sv
// keyword_feeder
//   Holds a list of keywords written as a byte stream (length byte followed by
//   that many characters) and serves them to the string matcher in batches.
//   Each batch packs as many whole keywords as fit into the MAXW character
//   lanes. The first character of a batch goes to lane MAXW, which is the top
//   byte of weight. One weight_enable pulse is issued per batch. When the last
//   batch of the list is issued, string_finish is raised so that the matcher
//   moves on to the next string.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   kw_wr_en/_byte      keyword byte stream (accepted only in IDLE)
//   kw_wr_ready         high while writes are accepted (IDLE)
//   start               begin serving batches (needs at least one keyword)
//   string_ready        matcher pulse: a new string is loaded
//   done                matcher: current batch finished
//   weight, len_arr     packed characters / per-slot keyword lengths
//   weight_count        keywords in the current batch
//   weight_enable       one-cycle batch-valid pulse
//   string_finish       current batch is the last one for this string
//   busy                not in IDLE
//   load_err            sticky: bad length byte or storage exhausted
//   string_count        strings fully served (wraps)
//   dbg_state           FSM state, for checkers
//   dbg_kw_count        number of committed keywords, for checkers
//
// Handshakes
//   A stream byte is consumed in any cycle where kw_wr_en and kw_wr_ready are
//   both high. A batch is valid in the cycle weight_enable is high and stays
//   on the outputs until the next batch. The matcher acknowledges a batch by
//   raising done for one cycle at any point after weight_enable. The matcher
//   samples string_finish in that same done cycle.
module keyword_feeder #(
  parameter int DWIDTH   = 8,
  parameter int groups   = 4,
  parameter int num      = 4,
  parameter int MAXW     = num * groups,
  parameter int MEM_SIZE = 512,
  parameter int MAX_KW   = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         kw_wr_en,
  input  logic [7:0]                   kw_wr_byte,
  output logic                         kw_wr_ready,
  input  logic                         start,
  input  logic                         string_ready,
  input  logic                         done,
  output logic [MAXW*DWIDTH-1:0]       weight,
  output logic [MAXW*8-1:0]            len_arr,
  output logic [7:0]                   weight_count,
  output logic                         weight_enable,
  output logic                         string_finish,
  output logic                         busy,
  output logic                         load_err,
  output logic [15:0]                  string_count,
  output logic [2:0]                   dbg_state,
  output logic [$clog2(MAX_KW+1)-1:0]  dbg_kw_count
);

  localparam int AW  = $clog2(MEM_SIZE);   // character address
  localparam int PW  = AW + 1;             // write pointer, can reach MEM_SIZE
  localparam int EW  = PW + 1;             // room check without overflow
  localparam int KIW = $clog2(MAX_KW);     // keyword table index
  localparam int KCW = $clog2(MAX_KW + 1); // keyword count

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_STR  = 3'd1,
    S_PACK      = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    P_LEN  = 2'd0,
    P_CHAR = 2'd1,
    P_SKIP = 2'd2
  } phase_t;

  state_t state, state_nxt;
  phase_t phase;

  // Storage (no reset: only entries below kw_count are ever read)
  logic [DWIDTH-1:0] mem     [MEM_SIZE];
  logic [AW-1:0]     kw_base [MAX_KW];
  logic [7:0]        kw_len  [MAX_KW];

  // Stream parser state
  logic [PW-1:0]  wr_ptr;
  logic [KCW-1:0] kw_count;
  logic [AW-1:0]  open_base;
  logic [7:0]     open_len;
  logic [7:0]     char_cnt;
  logic [7:0]     skip_cnt;

  // Packing state
  logic [KCW-1:0]         kw_idx;
  logic [7:0]             lp;       // next free lane, counts down from MAXW
  logic [7:0]             ch_idx;   // character within the current keyword
  logic [7:0]             slot;     // keywords already packed in this batch
  logic [MAXW*DWIDTH-1:0] lane_buf;
  logic [MAXW*8-1:0]      len_buf;

  logic wr_go;
  logic len_bad;
  logic no_room;

  logic [AW-1:0]     cur_base;
  logic [7:0]        cur_len;
  logic [DWIDTH-1:0] cur_char;
  logic              last_char;
  logic [KCW-1:0]    nxt_idx;
  logic [7:0]        nxt_len;
  logic              batch_close;

  assign kw_wr_ready  = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign dbg_state    = state;
  assign dbg_kw_count = kw_count;

  // ---------------------------------------------------------------- load
  assign wr_go   = kw_wr_en && (state == S_IDLE);
  assign len_bad = (kw_wr_byte == 8'd0) || (kw_wr_byte > 8'(MAXW));
  // A keyword that cannot be stored whole is dropped at its length byte, so
  // memory never holds a partial keyword.
  assign no_room = (kw_count == KCW'(MAX_KW)) ||
                   ((EW'(wr_ptr) + EW'(kw_wr_byte)) > EW'(MEM_SIZE));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase     <= P_LEN;
      wr_ptr    <= '0;
      kw_count  <= '0;
      open_base <= '0;
      open_len  <= '0;
      char_cnt  <= '0;
      skip_cnt  <= '0;
      load_err  <= 1'b0;
    end else if (wr_go) begin
      case (phase)
        P_LEN: begin
          if (kw_wr_byte == 8'd0) begin
            load_err <= 1'b1;
          end else if (len_bad || no_room) begin
            // Swallow the characters of the rejected keyword.
            load_err <= 1'b1;
            skip_cnt <= kw_wr_byte;
            phase    <= P_SKIP;
          end else begin
            open_base <= wr_ptr[AW-1:0];
            open_len  <= kw_wr_byte;
            char_cnt  <= '0;
            phase     <= P_CHAR;
          end
        end
        P_CHAR: begin
          wr_ptr <= wr_ptr + 1'b1;
          if (char_cnt == open_len - 8'd1) begin
            kw_count <= kw_count + 1'b1;
            phase    <= P_LEN;
          end else begin
            char_cnt <= char_cnt + 8'd1;
          end
        end
        P_SKIP: begin
          skip_cnt <= skip_cnt - 8'd1;
          if (skip_cnt == 8'd1) phase <= P_LEN;
        end
        default: phase <= P_LEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_go && (phase == P_CHAR)) begin
      mem[wr_ptr[AW-1:0]] <= DWIDTH'(kw_wr_byte);
      if (char_cnt == open_len - 8'd1) begin
        kw_base[kw_count[KIW-1:0]] <= open_base;
        kw_len[kw_count[KIW-1:0]]  <= open_len;
      end
    end
  end

  // ---------------------------------------------------------------- pack
  assign cur_base  = kw_base[kw_idx[KIW-1:0]];
  assign cur_len   = kw_len[kw_idx[KIW-1:0]];
  assign cur_char  = mem[cur_base + AW'(ch_idx)];
  assign last_char = (ch_idx == cur_len - 8'd1);
  assign nxt_idx   = kw_idx + 1'b1;
  assign nxt_len   = kw_len[nxt_idx[KIW-1:0]];

  // The fit test for the following keyword is made while the last character
  // of the current one is copied. A batch therefore costs exactly one cycle
  // per character. The first keyword of a batch always fits because every
  // stored length is at most MAXW.
  assign batch_close = last_char &&
                       ((nxt_idx == kw_count) || (nxt_len > lp - 8'd1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start && (kw_count != '0)) state_nxt = S_WAIT_STR;
      S_WAIT_STR:  if (string_ready) state_nxt = S_PACK;
      S_PACK:      if (batch_close) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (done) state_nxt = string_finish ? S_WAIT_STR : S_PACK;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kw_idx        <= '0;
      lp            <= 8'(MAXW);
      ch_idx        <= '0;
      slot          <= '0;
      lane_buf      <= '0;
      len_buf       <= '0;
      weight        <= '0;
      len_arr       <= '0;
      weight_count  <= '0;
      weight_enable <= 1'b0;
      string_finish <= 1'b0;
      string_count  <= '0;
    end else begin
      weight_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (kw_count != '0)) kw_idx <= '0;
        end
        S_WAIT_STR: begin
          if (string_ready) begin
            lane_buf <= '0;
            len_buf  <= '0;
            slot     <= '0;
            lp       <= 8'(MAXW);
            ch_idx   <= '0;
          end
        end
        S_PACK: begin
          for (int l = 1; l <= MAXW; l++) begin
            if (lp == 8'(l)) lane_buf[l*DWIDTH-1 -: DWIDTH] <= cur_char;
          end
          lp <= lp - 8'd1;
          if (last_char) begin
            // Slot b (1-based) of the batch lives at byte MAXW-b from the bottom.
            for (int s = 1; s <= MAXW; s++) begin
              if (slot + 8'd1 == 8'(s)) len_buf[(MAXW-s+1)*8-1 -: 8] <= cur_len;
            end
            slot   <= slot + 8'd1;
            kw_idx <= nxt_idx;
            ch_idx <= '0;
          end else begin
            ch_idx <= ch_idx + 8'd1;
          end
        end
        S_ISSUE: begin
          weight        <= lane_buf;
          len_arr       <= len_buf;
          weight_count  <= slot;
          weight_enable <= 1'b1;
          string_finish <= (kw_idx == kw_count);
        end
        S_WAIT_DONE: begin
          if (done) begin
            if (string_finish) begin
              string_count <= string_count + 16'd1;
              kw_idx       <= '0;
            end else begin
              lane_buf <= '0;
              len_buf  <= '0;
              slot     <= '0;
              lp       <= 8'(MAXW);
              ch_idx   <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keyword_feeder.sv
// Testbench for keyword_feeder.
module tb_keyword_feeder;

  localparam int MAXW = 16;
  localparam int W    = MAXW * 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         kw_wr_en = 1'b0;
  logic [7:0]   kw_wr_byte = 8'd0;
  logic         kw_wr_ready;
  logic         start = 1'b0;
  logic         string_ready = 1'b0;
  logic         done = 1'b0;
  logic [W-1:0] weight;
  logic [W-1:0] len_arr;
  logic [7:0]   weight_count;
  logic         weight_enable;
  logic         string_finish;
  logic         busy;
  logic         load_err;
  logic [15:0]  string_count;
  logic [2:0]   dbg_state;
  logic [6:0]   dbg_kw_count;

  keyword_feeder dut (
    .clk           (clk),
    .reset         (reset),
    .kw_wr_en      (kw_wr_en),
    .kw_wr_byte    (kw_wr_byte),
    .kw_wr_ready   (kw_wr_ready),
    .start         (start),
    .string_ready  (string_ready),
    .done          (done),
    .weight        (weight),
    .len_arr       (len_arr),
    .weight_count  (weight_count),
    .weight_enable (weight_enable),
    .string_finish (string_finish),
    .busy          (busy),
    .load_err      (load_err),
    .string_count  (string_count),
    .dbg_state     (dbg_state),
    .dbg_kw_count  (dbg_kw_count)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- scoreboard
  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference keyword list: what a correct loader keeps from the stream.
  logic [7:0] m_chars[$];
  int         m_len[$];
  int         m_base[$];
  bit         m_err;
  int         m_scount;

  task automatic model_clear();
    m_chars.delete();
    m_len.delete();
    m_base.delete();
    exp_q.delete();
    m_err    = 1'b0;
    m_scount = 0;
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_byte(input logic [7:0] b);
    kw_wr_en   = 1'b1;
    kw_wr_byte = b;
    @(negedge clk);
    kw_wr_en   = 1'b0;
  endtask

  // first_char < 0 gives random characters, else first_char, first_char+1, ...
  task automatic send_kw(input int len, input int first_char);
    logic [7:0] c;
    bit ok;
    ok = (len >= 1) && (len <= MAXW) && (m_len.size() < 64) && (m_chars.size() + len <= 512);
    if (!ok) m_err = 1'b1;
    else begin
      m_base.push_back(m_chars.size());
      m_len.push_back(len);
    end
    drive_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      c = (first_char < 0) ? 8'($urandom_range(0, 255)) : 8'(first_char + i);
      if (ok) m_chars.push_back(c);
      drive_byte(c);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_weight"},       weight, W'(0));
    check({tag, "_len_arr"},      len_arr, W'(0));
    check({tag, "_weight_count"}, W'(weight_count), W'(0));
    check({tag, "_enable"},       W'(weight_enable), W'(0));
    check({tag, "_finish"},       W'(string_finish), W'(0));
    check({tag, "_busy"},         W'(busy), W'(0));
    check({tag, "_load_err"},     W'(load_err), W'(0));
    check({tag, "_string_count"}, W'(string_count), W'(0));
    check({tag, "_wr_ready"},     W'(kw_wr_ready), W'(1));
    check({tag, "_kw_count"},     W'(dbg_kw_count), W'(0));
  endtask

  // Called just after a negedge; reset is asserted mid-cycle and checked at once.
  task automatic do_reset(input string tag);
    #2 reset = 1'b0;
    #1 check_cleared(tag);
    start = 1'b0; string_ready = 1'b0; done = 1'b0; kw_wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", W'(busy), W'(m_len.size() > 0));
    check("wr_ready_after_start", W'(kw_wr_ready), W'(m_len.size() == 0));
  endtask

  task automatic check_load();
    check("load_err", W'(load_err), W'(m_err));
    check("kw_count", W'(dbg_kw_count), W'(m_len.size()));
  endtask

  // Serves one string: string_ready, then every batch of the list, acking
  // each with done. Expected batches come from greedy whole-keyword packing.
  task automatic serve_string(input bit stray_done);
    int idx;
    int nch;
    int nk;
    int lat;
    int gap;
    bit fin;
    logic [W-1:0] ew;
    logic [W-1:0] el;
    idx = 0;
    fin = 1'b0;
    if (stray_done) begin
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("stray_done_enable", W'(weight_enable), W'(0));
      check("stray_done_scount", W'(string_count), W'(m_scount));
    end
    string_ready = 1'b1;
    while (!fin) begin
      ew = '0; el = '0; nch = 0; nk = 0;
      while (idx < m_len.size() && nch + m_len[idx] <= MAXW) begin
        for (int i = 0; i < m_len[idx]; i++) begin
          ew[(MAXW-nch)*8-1 -: 8] = m_chars[m_base[idx] + i];
          nch++;
        end
        nk++;
        el[(MAXW-nk+1)*8-1 -: 8] = 8'(m_len[idx]);
        idx++;
      end
      fin = (idx == m_len.size());
      exp_q.push_back(ew);
      lat = 0;
      for (int k = 1; k <= 200 && lat == 0; k++) begin
        @(negedge clk);
        string_ready = 1'b0;
        done = 1'b0;
        if (weight_enable) lat = k;
      end
      if (lat == 0) begin
        check("batch_timeout", W'(0), W'(1));
        exp_q.delete();
        fin = 1'b1;
      end else begin
        check("latency", W'(lat), W'(nch + 2));
        check("weight", weight, exp_q.pop_front());
        check("len_arr", len_arr, el);
        check("weight_count", W'(weight_count), W'(nk));
        check("string_finish", W'(string_finish), W'(fin));
        @(negedge clk);
        check("enable_one_cycle", W'(weight_enable), W'(0));
        check("weight_hold", weight, ew);
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          if ($urandom_range(0, 1) == 1) string_ready = 1'b1;
          @(negedge clk);
          string_ready = 1'b0;
          check("no_reissue_in_wait", W'(weight_enable), W'(0));
        end
        done = 1'b1;
        if ($urandom_range(0, 3) == 0) string_ready = 1'b1;
        if (fin) begin
          @(negedge clk);
          done = 1'b0;
          string_ready = 1'b0;
          m_scount++;
          check("string_count", W'(string_count), W'(m_scount));
          check("busy_between_strings", W'(busy), W'(1));
          check("finish_hold", W'(string_finish), W'(1));
        end
      end
    end
  endtask

  task automatic load_abc_defg();
    send_kw(3, 8'h61);
    send_kw(4, 8'h64);
    check_load();
  endtask

  task automatic check_abc_defg();
    check("top7_chars", W'(weight[W-1:W-56]), W'(56'h61626364656667));
    check("low_lanes_zero", W'(weight[W-57:0]), W'(0));
    check("len_top", W'(len_arr[W-1:W-16]), W'(16'h0304));
    check("len_rest_zero", W'(len_arr[W-17:0]), W'(0));
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    int n;
    int len;
    @(negedge clk);
    do_reset("rst0");

    // Two keywords in one batch
    load_abc_defg();
    do_start();
    serve_string(1'b0);
    check_abc_defg();

    // Reset in the middle of packing, then an identical rerun
    string_ready = 1'b1;
    @(negedge clk);
    string_ready = 1'b0;
    @(negedge clk);
    do_reset("rst_pack");
    load_abc_defg();
    do_start();
    serve_string(1'b1);
    check_abc_defg();

    // Five keywords of length 5: batches of 3 then 2
    do_reset("rst_five");
    for (int i = 0; i < 5; i++) send_kw(5, -1);
    check_load();
    do_start();
    serve_string(1'b0);

    // Bad length bytes then one good keyword
    do_reset("rst_err");
    send_kw(0, -1);
    send_kw(20, -1);
    send_kw(2, 8'h78);
    check_load();
    do_start();
    serve_string(1'b1);

    // start with an empty list is ignored
    do_reset("rst_empty");
    do_start();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("empty_stays_idle", W'(busy), W'(0));
    end

    // Three strings, one batch each
    send_kw(4, -1);
    send_kw(6, -1);
    send_kw(5, -1);
    check_load();
    do_start();
    for (int s = 0; s < 3; s++) serve_string(s == 1);
    check("three_strings", W'(string_count), W'(3));

    // Keyword table limit: 65 one-character keywords
    do_reset("rst_maxkw");
    for (int i = 0; i < 65; i++) send_kw(1, -1);
    check_load();
    do_start();
    serve_string(1'b0);

    // Character memory limit: 33 sixteen-character keywords
    do_reset("rst_memfull");
    for (int i = 0; i < 33; i++) send_kw(16, -1);
    check_load();
    do_start();
    serve_string(1'b0);

    // Random lists, with writes attempted while busy
    for (int r = 0; r < 6; r++) begin
      do_reset("rst_rand");
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(17, 30);
        else len = $urandom_range(1, 16);
        send_kw(len, -1);
      end
      check_load();
      do_start();
      if (m_len.size() > 0) begin
        drive_byte(8'd2);
        drive_byte(8'h41);
        drive_byte(8'h42);
        check("no_load_while_busy", W'(dbg_kw_count), W'(m_len.size()));
        serve_string($urandom_range(0, 1) == 1);
        serve_string($urandom_range(0, 1) == 1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
